nic_port_scheduler: RTL and testbench
=====================================

Name: nic_port_scheduler

Overview:
- Processor-side sequencer for the cardinal NIC. It shares the NIC's single addr/nicEn/nicWrEn access port between a transmit requester and a receive consumer.
- Transmit path: polls output-channel status (addr 11) and writes the packet to the output buffer (addr 10) only when status reads 0.
- Receive path: polls input-channel status (addr 01) and reads the input buffer (addr 00) only when status reads 1.
- Sits between the core/DMA logic and the NIC, replacing software polling loops.

Parameters:
- CNT_WIDTH, 16, width of the tx_count/rx_count packet counters (wrap modulo 2^CNT_WIDTH).
- POLL_GAP, 0, number of idle ARB cycles inserted after a failed poll (0 to 15).

Ports:
- clk  input  1  single clock, all state updates on posedge.
- reset  input  1  synchronous, active-high.
- nic_addr  output  2  NIC register address.
- nic_en  output  1  NIC access enable.
- nic_wr_en  output  1  NIC write enable.
- nic_d_in  output  64  data written to NIC.
- nic_d_out  input  64  combinational NIC read data for the current nic_addr.
- tx_valid  input  1  producer has a packet; tx_data stable while tx_valid=1 and tx_ready=0.
- tx_data  input  64  packet, passed unmodified (bit 63 is the VC bit set by the producer).
- tx_ready  output  1  one-cycle pulse; packet consumed this cycle.
- rx_valid  output  1  rx_data holds a received packet.
- rx_data  output  64  received packet.
- rx_ready  input  1  consumer takes rx_data this cycle when rx_valid=1.
- tx_en  input  1  enables transmit scheduling.
- rx_en  input  1  enables receive scheduling.
- tx_count  output  CNT_WIDTH  packets written to NIC.
- rx_count  output  CNT_WIDTH  packets read from NIC.

Behaviour:
- Reset (synchronous, active-high) values:
  - state=ARB, last_grant=RX (so TX wins the first tie), gap counter=0.
  - rx_valid=0, rx_data=0, tx_count=0, rx_count=0.
  - nic_en=0, nic_wr_en=0, nic_addr=00, nic_d_in=0, tx_ready=0.
- Reset asserted in any state aborts the operation. No NIC access is issued in the reset cycle.
- NIC outputs are Moore-decoded from state:
  - ARB: en=0, wr_en=0, addr=00, d_in=0.
  - TX_POLL: en=1, wr_en=0, addr=11.
  - TX_WRITE: en=1, wr_en=1, addr=10, d_in=tx_data, tx_ready=1.
  - RX_POLL: en=1, wr_en=0, addr=01.
  - RX_READ: en=1, wr_en=0, addr=00.
- Eligibility:
  - tx_elig = tx_en & tx_valid.
  - rx_elig = rx_en & (~rx_valid | rx_ready).
  - rx_ready is evaluated in the cycle of the decision.
- ARB:
  - If gap counter != 0: decrement it, stay in ARB.
  - Else if only one requester is eligible, grant it.
  - Else if both are eligible, grant the one not equal to last_grant.
  - Else stay in ARB.
  - A grant moves to TX_POLL or RX_POLL and updates last_grant.
- TX_POLL, sampled at the edge:
  - nic_d_out[0]=0 -> TX_WRITE.
  - Otherwise -> ARB, gap counter loaded with POLL_GAP.
- TX_WRITE: packet latched by the NIC at this edge; tx_count+1; -> ARB.
- RX_POLL:
  - nic_d_out[0]=1 -> RX_READ.
  - Otherwise -> ARB, gap counter loaded with POLL_GAP.
- RX_READ:
  - rx_data<=nic_d_out, rx_valid<=1, rx_count+1, -> ARB.
  - The NIC clears in_status at the same edge.
- rx_valid clears on rx_valid & rx_ready unless RX_READ loads a new word in the same cycle. A simultaneous read and take leaves rx_valid=1 with the new data.
- Why a successful poll is safe to act on: only this block sets NIC out_status and only this block clears in_status. A passing poll therefore still holds in the following action cycle.
- Minimum per-packet occupancy is 3 cycles (ARB, POLL, ACTION). Max TX throughput is 1 packet per 3 cycles.
- tx_valid dropping during TX_POLL is a producer protocol violation. The block still completes TX_WRITE with the current tx_data.
- Counters wrap modulo 2^CNT_WIDTH without saturation.
- Deasserting tx_en or rx_en mid-sequence does not abort a POLL/ACTION already entered. It only affects subsequent ARB decisions.

Test Plan:
- Reset, then tx_valid=1, tx_data=64'h8000_0000_0000_00AA, NIC out_status=0 -> cycle 1 addr=11 read; cycle 2 addr=10, wr_en=1, d_in=...00AA, tx_ready=1; tx_count=1.
- NIC in_status=1 with input buffer 64'h0000_0000_0000_1234, rx_ready=0 -> addr=01 then addr=00 read; rx_valid=1, rx_data=...1234; no further RX polls until rx_ready=1.
- Both eligible continuously, out_status toggling to 0 after each write, in_status=1 -> grants alternate TX,RX,TX,RX; first grant TX after reset.
- out_status stuck at 1, POLL_GAP=3 -> TX_POLL, then 3 ARB gap cycles, repeat; no wr_en ever asserted, tx_ready stays 0.
- rx_valid=1, rx_ready=1 in the same cycle as RX_READ -> rx_valid remains 1, rx_data is the new word, rx_count increments by 1.
- Reset asserted during TX_POLL -> next cycle nic_en=0, state ARB, counters 0; tx_count=16'hFFFF plus one write wraps to 0.

Source files
------------

// File: rtl/nic_port_scheduler.sv
// Arbitrates the NIC's single register port between a transmit producer and a
// receive consumer, polling channel status before every buffer access.
module nic_port_scheduler #(
  parameter int CNT_WIDTH = 16,
  parameter int POLL_GAP  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [1:0]           nic_addr,
  output logic                 nic_en,
  output logic                 nic_wr_en,
  output logic [63:0]          nic_d_in,
  input  logic [63:0]          nic_d_out,
  input  logic                 tx_valid,
  input  logic [63:0]          tx_data,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [63:0]          rx_data,
  input  logic                 rx_ready,
  input  logic                 tx_en,
  input  logic                 rx_en,
  output logic [CNT_WIDTH-1:0] tx_count,
  output logic [CNT_WIDTH-1:0] rx_count
);

  typedef enum logic [2:0] {
    S_ARB, S_TX_POLL, S_TX_WRITE, S_RX_POLL, S_RX_READ
  } state_t;

  typedef enum logic {GRANT_TX, GRANT_RX} grant_t;

  localparam logic [3:0] GAP_LOAD = 4'(POLL_GAP);

  state_t               r_state, w_state_nxt;
  grant_t               r_last_grant, w_last_grant_nxt;
  logic [3:0]           r_gap, w_gap_nxt;
  logic                 r_rx_valid;
  logic [63:0]          r_rx_data;
  logic [CNT_WIDTH-1:0] r_tx_count, r_rx_count;
  logic                 w_tx_elig, w_rx_elig;

  assign w_tx_elig = tx_en & tx_valid;
  assign w_rx_elig = rx_en & (~r_rx_valid | rx_ready);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_gap_nxt        = r_gap;
    case (r_state)
      S_ARB: begin
        if (r_gap != 4'd0) begin
          w_gap_nxt = r_gap - 4'd1;
        end else if (w_tx_elig && (!w_rx_elig || r_last_grant == GRANT_RX)) begin
          w_state_nxt      = S_TX_POLL;
          w_last_grant_nxt = GRANT_TX;
        end else if (w_rx_elig) begin
          w_state_nxt      = S_RX_POLL;
          w_last_grant_nxt = GRANT_RX;
        end
      end
      S_TX_POLL: begin
        if (!nic_d_out[0]) begin
          w_state_nxt = S_TX_WRITE;
        end else begin
          w_state_nxt = S_ARB;
          w_gap_nxt   = GAP_LOAD;
        end
      end
      S_RX_POLL: begin
        if (nic_d_out[0]) begin
          w_state_nxt = S_RX_READ;
        end else begin
          w_state_nxt = S_ARB;
          w_gap_nxt   = GAP_LOAD;
        end
      end
      default: w_state_nxt = S_ARB;
    endcase
  end

  // Moore decode; the reset cycle is forced idle so an aborted sequence never reaches the NIC.
  always_comb begin
    nic_en    = 1'b0;
    nic_wr_en = 1'b0;
    nic_addr  = 2'b00;
    nic_d_in  = '0;
    tx_ready  = 1'b0;
    if (!reset) begin
      case (r_state)
        S_TX_POLL: begin
          nic_en   = 1'b1;
          nic_addr = 2'b11;
        end
        S_TX_WRITE: begin
          nic_en    = 1'b1;
          nic_wr_en = 1'b1;
          nic_addr  = 2'b10;
          nic_d_in  = tx_data;
          tx_ready  = 1'b1;
        end
        S_RX_POLL: begin
          nic_en   = 1'b1;
          nic_addr = 2'b01;
        end
        S_RX_READ: begin
          nic_en   = 1'b1;
          nic_addr = 2'b00;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_ARB;
      r_last_grant <= GRANT_RX;
      r_gap        <= 4'd0;
      r_rx_valid   <= 1'b0;
      r_rx_data    <= '0;
      r_tx_count   <= '0;
      r_rx_count   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_gap        <= w_gap_nxt;
      if (r_state == S_TX_WRITE) r_tx_count <= r_tx_count + CNT_WIDTH'(1);
      // A fresh read wins over a same-cycle take, keeping the new word valid.
      if (r_state == S_RX_READ) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= nic_d_out;
        r_rx_count <= r_rx_count + CNT_WIDTH'(1);
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign tx_count = r_tx_count;
  assign rx_count = r_rx_count;

endmodule

// File: tb/tb_nic_port_scheduler.sv
// Self-checking bench: a behavioural NIC register model plus directed scenarios
// and a randomized run checked against access-ordering and data-flow rules.
module tb_nic_port_scheduler;

  localparam int CW  = 8;
  localparam int GAP = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    nic_addr;
  logic          nic_en, nic_wr_en;
  logic [63:0]   nic_d_in, nic_d_out;
  logic          tx_valid, tx_ready, rx_valid, rx_ready, tx_en, rx_en;
  logic [63:0]   tx_data, rx_data;
  logic [CW-1:0] tx_count, rx_count;

  // NIC model state: out_status=1 means the output buffer is still busy.
  logic        out_status, in_status;
  logic [63:0] in_buf;
  int          n_wr, n_rd;
  int          n_checks = 0;
  int          n_fail   = 0;

  nic_port_scheduler #(.CNT_WIDTH(CW), .POLL_GAP(GAP)) dut (
    .clk(clk), .reset(reset),
    .nic_addr(nic_addr), .nic_en(nic_en), .nic_wr_en(nic_wr_en),
    .nic_d_in(nic_d_in), .nic_d_out(nic_d_out),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_en(tx_en), .rx_en(rx_en),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  assign nic_d_out = (nic_addr == 2'b11) ? {63'd0, out_status} :
                     (nic_addr == 2'b01) ? {63'd0, in_status}  :
                     (nic_addr == 2'b00) ? in_buf : 64'd0;

  always #5 clk = ~clk;

  // One clock: note the access presented now, let the edge pass, apply NIC side effects.
  task automatic tick();
    logic p_wr, p_rd;
    p_wr = nic_en && nic_wr_en && (nic_addr == 2'b10);
    p_rd = nic_en && !nic_wr_en && (nic_addr == 2'b00);
    @(posedge clk);
    #1;
    if (p_wr) begin out_status = 1'b1; n_wr++; end
    if (p_rd) begin in_status = 1'b0; n_rd++; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_wr = 0;
    n_rd = 0;
  endtask

  task automatic test_reset();
    tx_valid = 1'b0; tx_en = 1'b0; rx_en = 1'b0; rx_ready = 1'b0; tx_data = '0;
    out_status = 1'b0; in_status = 1'b0; in_buf = '0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (nic_en !== 1'b0) begin n_fail++; $display("FAIL reset_cycle_en: got %b want 0", nic_en); end
    tick(); tick();
    reset = 1'b0;
    n_wr = 0; n_rd = 0;
    n_checks++;
    if (nic_en !== 1'b0 || nic_wr_en !== 1'b0 || nic_addr !== 2'b00 || nic_d_in !== 64'd0 || tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_nic: en=%b wr=%b addr=%b din=%h rdy=%b want all zero", nic_en, nic_wr_en, nic_addr, nic_d_in, tx_ready);
    end
    n_checks++;
    if (rx_valid !== 1'b0 || rx_data !== 64'd0 || tx_count !== '0 || rx_count !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rxv=%b rxd=%h txc=%0d rxc=%0d want all zero", rx_valid, rx_data, tx_count, rx_count);
    end
  endtask

  task automatic test_tx_single();
    tx_en = 1'b1; rx_en = 1'b0; tx_valid = 1'b1; tx_data = 64'h8000_0000_0000_00AA; out_status = 1'b0;
    tick();
    n_checks++;
    if (nic_en !== 1'b1 || nic_wr_en !== 1'b0 || nic_addr !== 2'b11 || tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_poll: en=%b wr=%b addr=%b rdy=%b want 1 0 11 0", nic_en, nic_wr_en, nic_addr, tx_ready);
    end
    tick();
    n_checks++;
    if (nic_en !== 1'b1 || nic_wr_en !== 1'b1 || nic_addr !== 2'b10 || nic_d_in !== 64'h8000_0000_0000_00AA || tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_write: en=%b wr=%b addr=%b din=%h rdy=%b want 1 1 10 80000000000000aa 1", nic_en, nic_wr_en, nic_addr, nic_d_in, tx_ready);
    end
    tick();
    tx_valid = 1'b0;
    n_checks++;
    if (tx_count !== CW'(1) || n_wr != 1 || nic_en !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_done: txc=%0d writes=%0d en=%b want 1 1 0", tx_count, n_wr, nic_en);
    end
  endtask

  task automatic test_rx_single();
    logic saw_en;
    rx_en = 1'b1; rx_ready = 1'b0; in_status = 1'b1; in_buf = 64'h0000_0000_0000_1234;
    tick();
    n_checks++;
    if (nic_en !== 1'b1 || nic_wr_en !== 1'b0 || nic_addr !== 2'b01) begin
      n_fail++; $display("FAIL rx_poll: en=%b wr=%b addr=%b want 1 0 01", nic_en, nic_wr_en, nic_addr);
    end
    tick();
    n_checks++;
    if (nic_en !== 1'b1 || nic_wr_en !== 1'b0 || nic_addr !== 2'b00) begin
      n_fail++; $display("FAIL rx_read: en=%b wr=%b addr=%b want 1 0 00", nic_en, nic_wr_en, nic_addr);
    end
    tick();
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 64'h1234 || rx_count !== CW'(1) || in_status !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_done: rxv=%b rxd=%h rxc=%0d in_status=%b want 1 1234 1 0", rx_valid, rx_data, rx_count, in_status);
    end
    in_status = 1'b1; in_buf = 64'hCAFE_F00D_0000_5678;
    saw_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (nic_en) saw_en = 1'b1;
      tick();
    end
    n_checks++;
    if (saw_en !== 1'b0 || rx_valid !== 1'b1 || rx_data !== 64'h1234) begin
      n_fail++; $display("FAIL rx_stall: saw_access=%b rxv=%b rxd=%h want 0 1 1234", saw_en, rx_valid, rx_data);
    end
  endtask

  task automatic test_rx_take_refill();
    rx_ready = 1'b1;
    tick();
    n_checks++;
    if (rx_valid !== 1'b0 || nic_en !== 1'b1 || nic_addr !== 2'b01) begin
      n_fail++; $display("FAIL take_grant: rxv=%b en=%b addr=%b want 0 1 01", rx_valid, nic_en, nic_addr);
    end
    tick();
    tick();
    rx_ready = 1'b0;
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 64'hCAFE_F00D_0000_5678 || rx_count !== CW'(2)) begin
      n_fail++; $display("FAIL take_refill: rxv=%b rxd=%h rxc=%0d want 1 cafef00d00005678 2", rx_valid, rx_data, rx_count);
    end
  endtask

  task automatic test_alternate();
    logic seq[$];
    logic consumed;
    do_reset();
    tx_en = 1'b1; rx_en = 1'b1; tx_valid = 1'b1; tx_data = 64'h8000_0000_0000_0001; rx_ready = 1'b1;
    out_status = 1'b0; in_status = 1'b1; in_buf = 64'h1111;
    for (int k = 0; k < 24; k++) begin
      if (nic_en && !nic_wr_en && nic_addr == 2'b11) seq.push_back(1'b1);
      if (nic_en && !nic_wr_en && nic_addr == 2'b01) seq.push_back(1'b0);
      consumed = tx_ready;
      tick();
      if (consumed) tx_data = tx_data + 64'd1;
      if (out_status) out_status = 1'b0;
      if (!in_status) begin in_status = 1'b1; in_buf = in_buf + 64'h1111; end
    end
    n_checks++;
    if (seq.size() != 8) begin n_fail++; $display("FAIL alt_grants: got %0d polls want 8", seq.size()); end
    for (int i = 0; i < seq.size(); i++) begin
      n_checks++;
      if (seq[i] !== ((i % 2) == 0)) begin
        n_fail++; $display("FAIL alt_order[%0d]: got tx=%b want tx=%b", i, seq[i], ((i % 2) == 0));
      end
    end
    n_checks++;
    if (tx_count !== CW'(4) || rx_count !== CW'(4)) begin
      n_fail++; $display("FAIL alt_counts: txc=%0d rxc=%0d want 4 4", tx_count, rx_count);
    end
  endtask

  task automatic test_poll_gap();
    logic exp_poll;
    do_reset();
    tx_en = 1'b1; tx_valid = 1'b1; rx_en = 1'b0; out_status = 1'b1;
    for (int k = 0; k < 20; k++) begin
      exp_poll = ((k % (GAP + 2)) == 1);
      n_checks++;
      if (nic_en !== exp_poll || nic_wr_en !== 1'b0 || tx_ready !== 1'b0 || (exp_poll && nic_addr !== 2'b11)) begin
        n_fail++;
        $display("FAIL gap_cycle[%0d]: en=%b wr=%b rdy=%b addr=%b want en=%b wr=0 rdy=0", k, nic_en, nic_wr_en, tx_ready, nic_addr, exp_poll);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tx_en = 1'b1; tx_valid = 1'b1; rx_en = 1'b0; out_status = 1'b0;
    tick(); tick(); tick();
    tx_data = 64'h0000_0000_0000_0BAD;
    out_status = 1'b0;
    tick();
    n_checks++;
    if (nic_en !== 1'b1 || nic_addr !== 2'b11 || n_wr != 1) begin
      n_fail++; $display("FAIL mid_setup: en=%b addr=%b writes=%0d want 1 11 1", nic_en, nic_addr, n_wr);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (nic_en !== 1'b0) begin n_fail++; $display("FAIL mid_reset_cycle: en=%b want 0", nic_en); end
    tick();
    n_checks++;
    if (nic_en !== 1'b0 || tx_count !== '0 || rx_count !== '0 || rx_valid !== 1'b0 || n_wr != 1) begin
      n_fail++;
      $display("FAIL mid_after: en=%b txc=%0d rxc=%0d rxv=%b writes=%0d want 0 0 0 0 1", nic_en, tx_count, rx_count, rx_valid, n_wr);
    end
    reset = 1'b0;
    n_wr = 0; n_rd = 0;
    tick();
    n_checks++;
    if (nic_en !== 1'b1 || nic_addr !== 2'b11) begin
      n_fail++; $display("FAIL mid_resume: en=%b addr=%b want 1 11", nic_en, nic_addr);
    end
  endtask

  task automatic test_wrap();
    int  guard;
    logic saw_max;
    do_reset();
    tx_en = 1'b1; tx_valid = 1'b1; rx_en = 1'b0; tx_data = 64'h8000_0000_0000_0777;
    out_status = 1'b0; in_status = 1'b0;
    guard = 0; saw_max = 1'b0;
    while (n_wr < (1 << CW) && guard < 2000) begin
      tick();
      guard++;
      if (out_status) out_status = 1'b0;
      if (n_wr == (1 << CW) - 1 && !saw_max) begin
        saw_max = 1'b1;
        n_checks++;
        if (tx_count !== {CW{1'b1}}) begin n_fail++; $display("FAIL wrap_max: txc=%0d want %0d", tx_count, (1 << CW) - 1); end
      end
    end
    n_checks++;
    if (n_wr != (1 << CW)) begin n_fail++; $display("FAIL wrap_timeout: writes=%0d want %0d", n_wr, 1 << CW); end
    n_checks++;
    if (tx_count !== '0) begin n_fail++; $display("FAIL wrap_zero: txc=%0d want 0", tx_count); end
  endtask

  task automatic test_random();
    logic prev_idle, prev_tx_elig, prev_rx_elig, prev_txp_ok, prev_rxp_ok;
    logic exp_rxv, is_txp, is_rxp, is_wr, is_rd, consumed;
    logic [63:0] exp_rxd;
    do_reset();
    tx_valid = 1'b0; tx_en = 1'b1; rx_en = 1'b1; rx_ready = 1'b0;
    out_status = 1'b0; in_status = 1'b0;
    prev_idle = 1'b1; prev_tx_elig = 1'b0; prev_rx_elig = 1'b0; prev_txp_ok = 1'b0; prev_rxp_ok = 1'b0;
    exp_rxv = 1'b0; exp_rxd = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!tx_valid && $urandom_range(0, 2) == 0) begin tx_valid = 1'b1; tx_data = {$urandom(), $urandom()}; end
      rx_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) tx_en = ~tx_en;
      if ($urandom_range(0, 19) == 0) rx_en = ~rx_en;
      if (out_status && $urandom_range(0, 2) == 0) out_status = 1'b0;
      if (!in_status && $urandom_range(0, 2) == 0) begin in_status = 1'b1; in_buf = {$urandom(), $urandom()}; end
      #0;
      is_txp = nic_en && !nic_wr_en && nic_addr == 2'b11;
      is_rxp = nic_en && !nic_wr_en && nic_addr == 2'b01;
      is_wr  = nic_en && nic_wr_en && nic_addr == 2'b10;
      is_rd  = nic_en && !nic_wr_en && nic_addr == 2'b00;
      n_checks++;
      if (tx_ready !== is_wr || (nic_wr_en && !is_wr)) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: rdy=%b wr=%b addr=%b", c, tx_ready, nic_wr_en, nic_addr);
      end
      n_checks++;
      if (!nic_en && (nic_wr_en !== 1'b0 || nic_addr !== 2'b00 || nic_d_in !== 64'd0)) begin
        n_fail++; $display("FAIL rnd_idle[%0d]: wr=%b addr=%b din=%h want 0 00 0", c, nic_wr_en, nic_addr, nic_d_in);
      end
      n_checks++;
      if (rx_valid !== exp_rxv || (exp_rxv && rx_data !== exp_rxd)) begin
        n_fail++; $display("FAIL rnd_rx[%0d]: rxv=%b rxd=%h want %b %h", c, rx_valid, rx_data, exp_rxv, exp_rxd);
      end
      if (is_wr) begin
        n_checks++;
        if (nic_d_in !== tx_data || !tx_valid || !prev_txp_ok) begin
          n_fail++; $display("FAIL rnd_write[%0d]: din=%h want %h, poll_ok=%b", c, nic_d_in, tx_data, prev_txp_ok);
        end
      end
      if (is_rd) begin
        n_checks++;
        if (!prev_rxp_ok) begin n_fail++; $display("FAIL rnd_read[%0d]: read without passing status poll", c); end
      end
      if (is_txp || is_rxp) begin
        n_checks++;
        if (!prev_idle || (is_txp && !prev_tx_elig) || (is_rxp && !prev_rx_elig)) begin
          n_fail++;
          $display("FAIL rnd_grant[%0d]: tx_poll=%b prev_idle=%b tx_elig=%b rx_elig=%b", c, is_txp, prev_idle, prev_tx_elig, prev_rx_elig);
        end
      end
      prev_idle    = !nic_en;
      prev_tx_elig = tx_en && tx_valid;
      prev_rx_elig = rx_en && (!exp_rxv || rx_ready);
      prev_txp_ok  = is_txp && !out_status;
      prev_rxp_ok  = is_rxp && in_status;
      if (is_rd) begin exp_rxv = 1'b1; exp_rxd = in_buf; end
      else if (exp_rxv && rx_ready) exp_rxv = 1'b0;
      consumed = tx_ready;
      tick();
      if (consumed) tx_valid = 1'b0;
      n_checks++;
      if (tx_count !== CW'(n_wr) || rx_count !== CW'(n_rd)) begin
        n_fail++; $display("FAIL rnd_count[%0d]: txc=%0d rxc=%0d want %0d %0d", c, tx_count, rx_count, CW'(n_wr), CW'(n_rd));
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_rx_single();
    test_rx_take_refill();
    test_alternate();
    test_poll_gap();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
